stream_demux: RTL and testbench

- Parametrised, registered, valid/ready stream demultiplexer: one input stream is routed to one of NUM_CH output channels by a select field sampled with the data.
- Generalises the combinational 4-way demux to configurable data width and channel count.
- Adds a one-entry output stage per channel with per-channel backpressure.
- Sits between the instruction/data fetch path and multiple consumers (memory-mapped peripherals, register-file write ports).

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 58 +++++
 rtl/stream_demux.sv | 107 ++++++++++
 tb/tb_stream_demux.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer.
// Contents: slot state encoding, error-counter width and the select-width helper.
package demux_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  // One-entry output slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select field width for a given channel count (at least one bit)
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output stage for a single demux channel.
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   load         - write load_data into the slot this cycle
//   load_data    - word to store
//   drain_ready  - consumer ready; a FULL slot empties when not refilled
//   valid        - slot holds a word
//   data         - stored word; held under backpressure and after draining
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data register: only loads overwrite, so the word survives draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end
  end

  // Next state; a load while FULL is a same-cycle drain-and-refill
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (!load && drain_ready) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  assign valid = (r_state == SLOT_FULL);
  assign data  = r_data;

endmodule

// File: rtl/stream_demux.sv
// Registered valid/ready stream demultiplexer: routes each input word to the
// channel named by in_sel through a one-entry slot per channel.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   in_data     - input word
//   in_sel      - destination channel, qualified by in_valid
//   in_valid    - input word present
//   in_ready    - input accepted this cycle (independent of in_valid)
//   out_data    - channel k at [k*WIDTH +: WIDTH]
//   out_valid   - per-channel valid
//   out_ready   - per-channel consumer ready
//   sel_err     - one-cycle pulse after accepting a word with in_sel >= NUM_CH
// Optional (macro STREAM_DEMUX_ERR_CNT_EN):
//   err_clr     - clear the error counter (wins over an increment)
//   err_cnt     - saturating count of sel_err pulses
module stream_demux
  import demux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
`ifdef STREAM_DEMUX_ERR_CNT_EN
  input  logic                    err_clr,
  output logic [ERR_CNT_W-1:0]    err_cnt,
`endif
  output logic                    sel_err
);

  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  logic                w_sel_ok;
  logic                w_accept;
  logic [SEL_SPAN-1:0] w_free;
  logic [NUM_CH-1:0]   w_load;
  logic [NUM_CH-1:0]   w_valid;
  logic                r_sel_err;

  assign w_sel_ok = (32'(in_sel) < NUM_CH);

  // Per-select readiness; codes beyond NUM_CH-1 are always free (dropped words)
  always_comb begin
    w_free = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      w_free[k] = ~w_valid[k] | out_ready[k];
    end
  end

  assign in_ready = w_free[in_sel];
  assign w_accept = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_load[k] = w_accept & (in_sel == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (w_load[k]),
      .load_data  (in_data),
      .drain_ready(out_ready[k]),
      .valid      (w_valid[k]),
      .data       (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = w_valid;

  // Flag an accepted out-of-range word for exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept & ~w_sel_ok;
    end
  end

  assign sel_err = r_sel_err;

`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating error counter; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (r_sel_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed steps on a 4-channel instance,
// out-of-range and random soak on a 5-channel instance against queue models.
module tb_stream_demux;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance A: 4 channels
  logic [15:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic        a_in_valid, a_in_ready;
  logic [63:0] a_out_data;
  logic [3:0]  a_out_valid, a_out_ready;
  logic        a_sel_err;

  // Instance B: 5 channels (select codes 5..7 are out of range)
  logic [15:0] b_in_data;
  logic [2:0]  b_in_sel;
  logic        b_in_valid, b_in_ready;
  logic [79:0] b_out_data;
  logic [4:0]  b_out_valid, b_out_ready;
  logic        b_sel_err;

`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic       a_err_clr, b_err_clr;
  logic [7:0] a_err_cnt, b_err_cnt;
`endif

  stream_demux #(.WIDTH(16), .NUM_CH(4)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_data  (a_in_data),
    .in_sel   (a_in_sel),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .out_data (a_out_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
`ifdef STREAM_DEMUX_ERR_CNT_EN
    .err_clr  (a_err_clr),
    .err_cnt  (a_err_cnt),
`endif
    .sel_err  (a_sel_err)
  );

  stream_demux #(.WIDTH(16), .NUM_CH(5)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_data  (b_in_data),
    .in_sel   (b_in_sel),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
`ifdef STREAM_DEMUX_ERR_CNT_EN
    .err_clr  (b_err_clr),
    .err_cnt  (b_err_cnt),
`endif
    .sel_err  (b_sel_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane_a(input int k);
    return a_out_data[k*16 +: 16];
  endfunction

  function automatic logic [15:0] lane_b(input int k);
    return b_out_data[k*16 +: 16];
  endfunction

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model for instance B: one in-flight queue per channel
  logic [15:0] q [5][$];
  logic        exp_err;
  logic        exp_rdy;
  logic [4:0]  exp_vld;
  int          pend;

  initial begin
    reset = 1'b1;
    a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = '1;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = '1;
`ifdef STREAM_DEMUX_ERR_CNT_EN
    a_err_clr = 1'b0; b_err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_valid", 80'(a_out_valid), 80'h0);
    chk("rst_a_data",  80'(a_out_data),  80'h0);
    chk("rst_a_err",   80'(a_sel_err),   80'h0);
    chk("rst_b_valid", 80'(b_out_valid), 80'h0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("rst_b_errcnt", 80'(b_err_cnt), 80'h0);
`endif
    @(negedge clk); reset = 1'b0;

    // Basic routing
    @(negedge clk); a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 16'hA5A5;
    #1 chk("basic_rdy", 80'(a_in_ready), 80'h1);
    @(negedge clk); a_in_valid = 1'b0;
    #1 chk("basic_valid", 80'(a_out_valid), 80'h4);
    chk("basic_data", 80'(a_out_data[47:32]), 80'hA5A5);

    // Back-to-back sweep of all lanes
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); a_in_valid = 1'b1; a_in_sel = 2'(s); a_in_data = 16'(16'h1000 + s);
      #1 chk("sweep_rdy", 80'(a_in_ready), 80'h1);
      if (s > 0) begin
        chk("sweep_valid", 80'(a_out_valid), 80'(1 << (s - 1)));
        chk("sweep_data", 80'(lane_a(s - 1)), 80'(16'h1000 + s - 1));
      end
    end
    @(negedge clk); a_in_valid = 1'b0;
    #1 chk("sweep_valid3", 80'(a_out_valid), 80'h8);
    chk("sweep_data3", 80'(lane_a(3)), 80'h1003);
    @(negedge clk);
    #1 chk("sweep_idle", 80'(a_out_valid), 80'h0);

    // Backpressure isolation on channel 1
    a_out_ready = 4'b1101;
    @(negedge clk); a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 16'h1111;
    #1 chk("bp_rdy1", 80'(a_in_ready), 80'h1);
    @(negedge clk); a_in_data = 16'h2222;
    #1 chk("bp_full", 80'(a_out_valid), 80'h2);
    chk("bp_data", 80'(lane_a(1)), 80'h1111);
    chk("bp_block", 80'(a_in_ready), 80'h0);
    @(negedge clk);
    #1 chk("bp_stable", 80'(lane_a(1)), 80'h1111);
    chk("bp_block2", 80'(a_in_ready), 80'h0);
    @(negedge clk); a_in_sel = 2'd3; a_in_data = 16'h3333;
    #1 chk("bp_other_rdy", 80'(a_in_ready), 80'h1);
    @(negedge clk); a_in_sel = 2'd1; a_in_data = 16'h2222;
    #1 chk("bp_other_valid", 80'(a_out_valid), 80'hA);
    chk("bp_other_data", 80'(lane_a(3)), 80'h3333);
    chk("bp_hold_data", 80'(lane_a(1)), 80'h1111);
    chk("bp_block3", 80'(a_in_ready), 80'h0);
    @(negedge clk); a_out_ready = 4'b1111;
    #1 chk("bp_release_rdy", 80'(a_in_ready), 80'h1);
    chk("bp_release_valid", 80'(a_out_valid), 80'h2);
    @(negedge clk); a_in_valid = 1'b0;
    #1 chk("bp_second_valid", 80'(a_out_valid), 80'h2);
    chk("bp_second_data", 80'(lane_a(1)), 80'h2222);
    @(negedge clk);
    #1 chk("bp_idle", 80'(a_out_valid), 80'h0);

    // Pass-through refill on channel 0
    a_out_ready = 4'b0000;
    @(negedge clk); a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 16'h0BEE;
    @(negedge clk); a_in_data = 16'h1234; a_out_ready = 4'b1111;
    #1 chk("pt_rdy", 80'(a_in_ready), 80'h1);
    chk("pt_old", 80'(lane_a(0)), 80'h0BEE);
    @(negedge clk); a_in_valid = 1'b0;
    #1 chk("pt_valid", 80'(a_out_valid), 80'h1);
    chk("pt_new", 80'(lane_a(0)), 80'h1234);
    @(negedge clk);
    #1 chk("pt_empty", 80'(a_out_valid), 80'h0);
    chk("pt_keep", 80'(lane_a(0)), 80'h1234);

    // Reset mid-traffic, checked before any clock edge
    a_out_ready = 4'b0000;
    @(negedge clk); a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 16'h5555;
    @(negedge clk); a_in_sel = 2'd2; a_in_data = 16'h7777;
    @(negedge clk); a_in_valid = 1'b0;
    #1 chk("mid_pre", 80'(a_out_valid), 80'h5);
    #2 reset = 1'b1;
    #1 chk("mid_valid", 80'(a_out_valid), 80'h0);
    chk("mid_data", 80'(a_out_data), 80'h0);
    chk("mid_err", 80'(a_sel_err), 80'h0);
    @(negedge clk); reset = 1'b0; a_out_ready = 4'b1111;

    // Out-of-range and top-lane boundary on instance B
    @(negedge clk); b_in_valid = 1'b1; b_in_sel = 3'd4; b_in_data = 16'hC0DE;
    #1 chk("b4_rdy", 80'(b_in_ready), 80'h1);
    @(negedge clk); b_in_sel = 3'd5; b_in_data = 16'hDEAD;
    #1 chk("b5_rdy", 80'(b_in_ready), 80'h1);
    chk("b4_valid", 80'(b_out_valid), 80'h10);
    chk("b4_data", 80'(lane_b(4)), 80'hC0DE);
    chk("b4_noerr", 80'(b_sel_err), 80'h0);
    @(negedge clk); b_in_valid = 1'b0;
    #1 chk("b5_err", 80'(b_sel_err), 80'h1);
    chk("b5_novalid", 80'(b_out_valid), 80'h0);
    @(negedge clk);
    #1 chk("b5_err_pulse", 80'(b_sel_err), 80'h0);

`ifdef STREAM_DEMUX_ERR_CNT_EN
    // Saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); b_in_valid = 1'b1; b_in_sel = 3'd7; b_in_data = 16'(i);
    end
    @(negedge clk); b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("errcnt_sat", 80'(b_err_cnt), 80'd255);
    @(negedge clk); b_in_valid = 1'b1; b_in_sel = 3'd6;
    @(negedge clk); b_in_valid = 1'b0; b_err_clr = 1'b1;
    #1 chk("errclr_pulse", 80'(b_sel_err), 80'h1);
    @(negedge clk); b_err_clr = 1'b0;
    #1 chk("errclr_wins", 80'(b_err_cnt), 80'h0);
    @(negedge clk);
    #1 chk("errclr_hold", 80'(b_err_cnt), 80'h0);
`endif

    // Random soak on instance B
    @(negedge clk);
    exp_err = 1'b0;
    pend = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (pend == 0) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_sel   = 3'($urandom_range(0, 7));
        b_in_data  = 16'($urandom);
      end
      for (int k = 0; k < 5; k++) b_out_ready[k] = ($urandom_range(0, 9) < 7);
      exp_rdy = (b_in_sel >= 3'd5) || (q[b_in_sel].size() == 0) || b_out_ready[b_in_sel];
      for (int k = 0; k < 5; k++) exp_vld[k] = (q[k].size() != 0);
      #1;
      chk("soak_rdy", 80'(b_in_ready), 80'(exp_rdy));
      chk("soak_valid", 80'(b_out_valid), 80'(exp_vld));
      chk("soak_err", 80'(b_sel_err), 80'(exp_err));
      for (int k = 0; k < 5; k++)
        if (q[k].size() != 0) chk("soak_data", 80'(lane_b(k)), 80'(q[k][0]));
      @(posedge clk);
      for (int k = 0; k < 5; k++)
        if (q[k].size() != 0 && b_out_ready[k]) void'(q[k].pop_front());
      exp_err = b_in_valid && exp_rdy && (b_in_sel >= 3'd5);
      if (b_in_valid && exp_rdy && b_in_sel < 3'd5) q[b_in_sel].push_back(b_in_data);
      pend = (b_in_valid && !exp_rdy) ? 1 : 0;
    end

    // Drain and confirm nothing is left in flight
    @(negedge clk); b_in_valid = 1'b0; b_out_ready = '1;
    for (int k = 0; k < 5; k++) exp_vld[k] = (q[k].size() != 0);
    #1 chk("drain_valid", 80'(b_out_valid), 80'(exp_vld));
    @(negedge clk);
    #1 chk("drain_empty", 80'(b_out_valid), 80'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
